// File: rtl/counter_x3.sv
// rtl/counter_x3.sv - three-channel 32-bit down-counter/timer peripheral
//
// Purpose:
//   Three independent 32-bit down-counters with reload registers, plus one
//   shared 9-bit control register. Each channel runs in one of three modes:
//   one-shot, rate generator or square wave. Channels count on their tick
//   input, but only while enabled and while the count is non-zero.
//
// Control register ctrl[8:0]:
//   [1:0] mode ch0, [3:2] mode ch1, [5:4] mode ch2
//   (00 one-shot, 01 rate generator, 10 square wave, 11 same as 00)
//   [6+i] count enable for channel i
//
// Ports:
//   clk           in   1   system clock, all state on rising edge
//   rst           in   1   synchronous reset, active-low
//   counter_we    in   1   write strobe from the I/O bus decoder
//   counter_val   in  32   write data (bus Peripheral_in)
//   counter_ch    in   2   00/01/10 select channel 0/1/2, 11 selects ctrl
//   tick          in   3   per-channel count-enable pulses
//   counter_out   out 32   combinational readback of the selected register
//   counter0_out  out  1   channel 0 output
//   counter1_out  out  1   channel 1 output
//   counter2_out  out  1   channel 2 output
//
// Build option:
//   COUNTER_PRESCALE_EN - when defined, channel 2 counts on an internal
//   prescaler pulse (one per PRESCALE_DIV clocks) instead of tick[2].

module counter_x3 #(
    parameter logic [8:0]  CTRL_RST     = 9'h000,
    parameter int unsigned PRESCALE_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        counter_we,
    input  logic [31:0] counter_val,
    input  logic [1:0]  counter_ch,
    input  logic [2:0]  tick,
    output logic [31:0] counter_out,
    output logic        counter0_out,
    output logic        counter1_out,
    output logic        counter2_out
);

    localparam logic [1:0] MODE_ONE_SHOT = 2'b00;
    localparam logic [1:0] MODE_RATE     = 2'b01;
    localparam logic [1:0] MODE_SQUARE   = 2'b10;
    localparam logic [1:0] MODE_ALIAS    = 2'b11;
    localparam logic [1:0] CH_CTRL       = 2'b11;

    logic [8:0]  ctrl_q;
    logic        ctrl_wr;
    logic [2:0]  tick_eff;
    logic [2:0]  out_vec;
    logic [31:0] count_vis [3];

    assign ctrl_wr = counter_we && (counter_ch == CH_CTRL);

    // ------------------------------------------------------------------
    // Tick source selection
    // ------------------------------------------------------------------
`ifdef COUNTER_PRESCALE_EN
    localparam int unsigned      PRE_W    = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE_DIV - 1);

    logic [PRE_W-1:0] pre_cnt;
    logic             pre_pulse;
    logic             unused_tick2;

    // Free-running divider; the pulse is high for the one cycle in which
    // the divider sits at 0 after wrapping, independent of the enables.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pre_cnt   <= '0;
            pre_pulse <= 1'b0;
        end else begin
            pre_pulse <= (pre_cnt == PRE_LAST);
            if (pre_cnt == PRE_LAST) begin
                pre_cnt <= '0;
            end else begin
                pre_cnt <= pre_cnt + PRE_W'(1);
            end
        end
    end

    assign tick_eff     = {pre_pulse, tick[1:0]};
    assign unused_tick2 = tick[2];
`else
    logic [31:0] unused_prescale_div;

    assign tick_eff            = tick;
    assign unused_prescale_div = PRESCALE_DIV;
`endif

    // ------------------------------------------------------------------
    // Control register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            ctrl_q <= CTRL_RST;
        end else if (ctrl_wr) begin
            ctrl_q <= counter_val[8:0];
        end
    end

    // ------------------------------------------------------------------
    // Channels
    // ------------------------------------------------------------------
    for (genvar i = 0; i < 3; i++) begin : g_ch
        logic [31:0] count_r;
        logic [31:0] count_d;
        logic [31:0] reload_r;
        logic [31:0] reload_d;
        logic        out_r;
        logic        out_d;
        logic [1:0]  mode_raw;
        logic [1:0]  mode;
        logic        enable;
        logic        data_wr;

        assign mode_raw = ctrl_q[2*i +: 2];
        assign mode     = (mode_raw == MODE_ALIAS) ? MODE_ONE_SHOT : mode_raw;
        assign enable   = ctrl_q[6+i];
        assign data_wr  = counter_we && (counter_ch == 2'(i));

        always_comb begin
            count_d  = count_r;
            reload_d = reload_r;
            out_d    = out_r;

            // The rate-generator pulse lasts one cycle: it drops on every
            // edge unless a terminal event re-asserts it below.
            if (mode == MODE_RATE) begin
                out_d = 1'b0;
            end

            if (data_wr) begin
                // A load wins over a tick arriving in the same cycle.
                reload_d = counter_val;
                count_d  = counter_val;
                out_d    = 1'b0;
            end else if (enable && tick_eff[i] && (count_r != 32'd0)) begin
                if (count_r == 32'd1) begin
                    case (mode)
                        MODE_RATE: begin
                            count_d = reload_r;
                            out_d   = 1'b1;
                        end
                        MODE_SQUARE: begin
                            count_d = reload_r;
                            out_d   = ~out_r;
                        end
                        default: begin
                            // One-shot parks at zero, which also stops counting.
                            count_d = 32'd0;
                            out_d   = 1'b1;
                        end
                    endcase
                end else begin
                    count_d = count_r - 32'd1;
                end
            end

            // Changing this channel's mode field restarts its output low.
            if (ctrl_wr && (counter_val[2*i +: 2] != mode_raw)) begin
                out_d = 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                count_r  <= 32'd0;
                reload_r <= 32'd0;
                out_r    <= 1'b0;
            end else begin
                count_r  <= count_d;
                reload_r <= reload_d;
                out_r    <= out_d;
            end
        end

        assign count_vis[i] = count_r;
        assign out_vec[i]   = out_r;
    end

    // ------------------------------------------------------------------
    // Readback and outputs
    // ------------------------------------------------------------------
    always_comb begin
        counter_out = 32'd0;
        case (counter_ch)
            2'b00:   counter_out = count_vis[0];
            2'b01:   counter_out = count_vis[1];
            2'b10:   counter_out = count_vis[2];
            default: counter_out = {23'd0, ctrl_q};
        endcase
    end

    assign counter0_out = out_vec[0];
    assign counter1_out = out_vec[1];
    assign counter2_out = out_vec[2];

endmodule

// File: tb/tb_counter_x3.sv
// tb/tb_counter_x3.sv - self-checking bench for counter_x3

module tb_counter_x3;

    logic        clk;
    logic        rst;
    logic        counter_we;
    logic [31:0] counter_val;
    logic [1:0]  counter_ch;
    logic [2:0]  tick;
    logic [31:0] counter_out;
    logic        counter0_out;
    logic        counter1_out;
    logic        counter2_out;

    int n_tests = 0;
    int n_fail  = 0;

    counter_x3 dut (
        .clk          (clk),
        .rst          (rst),
        .counter_we   (counter_we),
        .counter_val  (counter_val),
        .counter_ch   (counter_ch),
        .tick         (tick),
        .counter_out  (counter_out),
        .counter0_out (counter0_out),
        .counter1_out (counter1_out),
        .counter2_out (counter2_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        we;
        logic [1:0]  ch;
        logic [31:0] val;
        logic [2:0]  tk;
        int          rep;
        logic [1:0]  rd;
        logic [31:0] exp_rd;
        logic [2:0]  exp_o;
    } vec_t;

    vec_t vecs[$];

    // Reference model state
    logic [31:0] m_count  [3];
    logic [31:0] m_reload [3];
    logic [8:0]  m_ctrl;
    logic [2:0]  m_out;

    task automatic add(input logic r, input logic we_v, input logic [1:0] ch_v,
                       input logic [31:0] v, input logic [2:0] t, input int rep,
                       input logic [1:0] rd, input logic [31:0] er, input logic [2:0] eo);
        vec_t x;
        x.r = r; x.we = we_v; x.ch = ch_v; x.val = v; x.tk = t;
        x.rep = rep; x.rd = rd; x.exp_rd = er; x.exp_o = eo;
        vecs.push_back(x);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic we_v, input logic [1:0] ch_v,
                              input logic [31:0] v, input logic [2:0] t);
        logic [8:0] old_ctrl;
        logic [1:0] md;
        old_ctrl = m_ctrl;
        if (!r) begin
            for (int i = 0; i < 3; i++) begin
                m_count[i]  = 32'd0;
                m_reload[i] = 32'd0;
            end
            m_out  = 3'b000;
            m_ctrl = 9'h000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                md = old_ctrl[2*i +: 2];
                if (md == 2'd3) md = 2'd0;
                if (md == 2'd1) m_out[i] = 1'b0;
                if (we_v && ch_v == 2'(i)) begin
                    m_reload[i] = v;
                    m_count[i]  = v;
                    m_out[i]    = 1'b0;
                end else if (old_ctrl[6+i] && t[i] && m_count[i] != 0) begin
                    if (m_count[i] > 1) begin
                        m_count[i] = m_count[i] - 1;
                    end else if (md == 2'd0) begin
                        m_count[i] = 0;
                        m_out[i]   = 1'b1;
                    end else if (md == 2'd1) begin
                        m_count[i] = m_reload[i];
                        m_out[i]   = 1'b1;
                    end else begin
                        m_count[i] = m_reload[i];
                        m_out[i]   = ~m_out[i];
                    end
                end
                if (we_v && ch_v == 2'd3 && v[2*i +: 2] != old_ctrl[2*i +: 2]) m_out[i] = 1'b0;
            end
            if (we_v && ch_v == 2'd3) m_ctrl = v[8:0];
        end
    endtask

    task automatic drive_cycle(input logic r, input logic we_v, input logic [1:0] ch_v,
                               input logic [31:0] v, input logic [2:0] t);
        @(negedge clk);
        rst = r; counter_we = we_v; counter_ch = ch_v; counter_val = v; tick = t;
        @(posedge clk);
        #1;
        model_step(r, we_v, ch_v, v, t);
        counter_we = 1'b0;
        tick = 3'b000;
    endtask

    initial begin
        logic [1:0]  rd;
        logic [1:0]  ch_r;
        logic [31:0] v_r;
        logic        we_r;
        logic        r_r;
        logic [31:0] exp_rd;

        rst = 1'b0; counter_we = 1'b0; counter_val = 32'd0; counter_ch = 2'd0; tick = 3'b000;
        for (int i = 0; i < 3; i++) begin
            m_count[i] = 0; m_reload[i] = 0;
        end
        m_ctrl = 0; m_out = 0;

        // reset
        add(1'b0, 1'b0, 2'd0, 32'd0,     3'b000, 2, 2'd3, 32'd0,     3'b000);
        add(1'b1, 1'b1, 2'd0, 32'd5,     3'b000, 1, 2'd0, 32'd5,     3'b000);
        add(1'b1, 1'b1, 2'd1, 32'd7,     3'b000, 1, 2'd1, 32'd7,     3'b000);
        add(1'b1, 1'b1, 2'd3, 32'h1FF,   3'b000, 1, 2'd3, 32'h1FF,   3'b000);
        add(1'b0, 1'b1, 2'd2, 32'd9,     3'b000, 1, 2'd2, 32'd0,     3'b000);
        add(1'b0, 1'b0, 2'd0, 32'd0,     3'b000, 1, 2'd0, 32'd0,     3'b000);
        add(1'b1, 1'b0, 2'd0, 32'd0,     3'b000, 1, 2'd1, 32'd0,     3'b000);
        add(1'b1, 1'b0, 2'd0, 32'd0,     3'b000, 1, 2'd3, 32'd0,     3'b000);
        // one-shot
        add(1'b1, 1'b1, 2'd3, 32'h040,   3'b000, 1, 2'd3, 32'h040,   3'b000);
        add(1'b1, 1'b1, 2'd0, 32'd3,     3'b000, 1, 2'd0, 32'd3,     3'b000);
        add(1'b1, 1'b0, 2'd0, 32'd0,     3'b001, 1, 2'd0, 32'd2,     3'b000);
        add(1'b1, 1'b0, 2'd0, 32'd0,     3'b001, 1, 2'd0, 32'd1,     3'b000);
        add(1'b1, 1'b0, 2'd0, 32'd0,     3'b001, 1, 2'd0, 32'd0,     3'b001);
        add(1'b1, 1'b0, 2'd0, 32'd0,     3'b001, 5, 2'd0, 32'd0,     3'b001);
        add(1'b1, 1'b1, 2'd0, 32'd3,     3'b000, 1, 2'd0, 32'd3,     3'b000);
        // rate generator
        add(1'b1, 1'b1, 2'd3, 32'h084,   3'b000, 1, 2'd3, 32'h084,   3'b000);
        add(1'b1, 1'b1, 2'd1, 32'd2,     3'b000, 1, 2'd1, 32'd2,     3'b000);
        for (int k = 0; k < 3; k++) begin
            add(1'b1, 1'b0, 2'd0, 32'd0, 3'b010, 1, 2'd1, 32'd1,     3'b000);
            add(1'b1, 1'b0, 2'd0, 32'd0, 3'b010, 1, 2'd1, 32'd2,     3'b010);
        end
        add(1'b1, 1'b0, 2'd0, 32'd0,     3'b000, 1, 2'd1, 32'd2,     3'b000);
        // collision and gating
        add(1'b1, 1'b1, 2'd3, 32'h040,   3'b000, 1, 2'd3, 32'h040,   3'b000);
        add(1'b1, 1'b1, 2'd0, 32'd10,    3'b001, 1, 2'd0, 32'd10,    3'b000);
        add(1'b1, 1'b1, 2'd3, 32'h000,   3'b000, 1, 2'd3, 32'h000,   3'b000);
        add(1'b1, 1'b0, 2'd0, 32'd0,     3'b001, 5, 2'd0, 32'd10,    3'b000);
        add(1'b1, 1'b1, 2'd3, 32'h040,   3'b000, 1, 2'd0, 32'd10,    3'b000);
        add(1'b1, 1'b0, 2'd0, 32'd0,     3'b001, 1, 2'd0, 32'd9,     3'b000);
        // idle channel
        add(1'b1, 1'b1, 2'd3, 32'h084,   3'b000, 1, 2'd3, 32'h084,   3'b000);
        add(1'b1, 1'b1, 2'd1, 32'd0,     3'b000, 1, 2'd1, 32'd0,     3'b000);
        add(1'b1, 1'b0, 2'd0, 32'd0,     3'b010, 20, 2'd1, 32'd0,    3'b000);
        // square wave, then reload of 1
        add(1'b1, 1'b1, 2'd3, 32'h120,   3'b000, 1, 2'd3, 32'h120,   3'b000);
        add(1'b1, 1'b1, 2'd2, 32'd4,     3'b000, 1, 2'd2, 32'd4,     3'b000);
        add(1'b1, 1'b0, 2'd0, 32'd0,     3'b100, 1, 2'd2, 32'd3,     3'b000);
        add(1'b1, 1'b0, 2'd0, 32'd0,     3'b100, 1, 2'd2, 32'd2,     3'b000);
        add(1'b1, 1'b0, 2'd0, 32'd0,     3'b100, 1, 2'd2, 32'd1,     3'b000);
        add(1'b1, 1'b0, 2'd0, 32'd0,     3'b100, 1, 2'd2, 32'd4,     3'b100);
        add(1'b1, 1'b0, 2'd0, 32'd0,     3'b100, 1, 2'd2, 32'd3,     3'b100);
        add(1'b1, 1'b0, 2'd0, 32'd0,     3'b100, 1, 2'd2, 32'd2,     3'b100);
        add(1'b1, 1'b0, 2'd0, 32'd0,     3'b100, 1, 2'd2, 32'd1,     3'b100);
        add(1'b1, 1'b0, 2'd0, 32'd0,     3'b100, 1, 2'd2, 32'd4,     3'b000);
        add(1'b1, 1'b1, 2'd2, 32'd1,     3'b000, 1, 2'd2, 32'd1,     3'b000);
        add(1'b1, 1'b0, 2'd0, 32'd0,     3'b100, 1, 2'd2, 32'd1,     3'b100);
        add(1'b1, 1'b0, 2'd0, 32'd0,     3'b100, 1, 2'd2, 32'd1,     3'b000);
        add(1'b1, 1'b0, 2'd0, 32'd0,     3'b100, 1, 2'd2, 32'd1,     3'b100);

        for (int k = 0; k < vecs.size(); k++) begin
            for (int j = 0; j < vecs[k].rep; j++) begin
                drive_cycle(vecs[k].r, vecs[k].we, vecs[k].ch, vecs[k].val, vecs[k].tk);
                counter_ch = vecs[k].rd;
                #1;
                chk($sformatf("row%0d_rd%0d", k, vecs[k].rd), counter_out, vecs[k].exp_rd);
                chk($sformatf("row%0d_outs", k),
                    {29'd0, counter2_out, counter1_out, counter0_out}, {29'd0, vecs[k].exp_o});
            end
        end

        // Randomised run against the reference model
        drive_cycle(1'b0, 1'b0, 2'd0, 32'd0, 3'b000);
        for (int n = 0; n < 3000; n++) begin
            r_r  = ($urandom_range(0, 63) != 0);
            we_r = ($urandom_range(0, 7) == 0);
            ch_r = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       v_r = 32'($urandom_range(0, 1));
                1:       v_r = 32'($urandom_range(1, 6));
                2:       v_r = $urandom;
                default: v_r = 32'($urandom_range(2, 4));
            endcase
            if (we_r && ch_r == 2'd3 && $urandom_range(0, 1) == 0) v_r[8:6] = 3'b111;
            drive_cycle(r_r, we_r, ch_r, v_r, 3'($urandom_range(0, 7)));
            rd = 2'($urandom_range(0, 3));
            counter_ch = rd;
            #1;
            exp_rd = (rd == 2'd3) ? {23'd0, m_ctrl} : m_count[rd];
            chk($sformatf("rand%0d_rd%0d", n, rd), counter_out, exp_rd);
            chk($sformatf("rand%0d_outs", n),
                {29'd0, counter2_out, counter1_out, counter0_out}, {29'd0, m_out});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
